// File: rtl/video_pkg.sv
// Shared widths, default raster timing and the porch averager state encoding
// for the video front end.
package video_pkg;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int CVBS_W   = 6;
  localparam int SUM_W    = 12;

  localparam int DEF_PORCH_SAMPLES = 32;
  localparam int DEF_GAIN_SHIFT    = 1;
  localparam int DEF_H_START       = 250;
  localparam int DEF_H_ACTIVE      = 1248;
  localparam int DEF_V_START       = 22;
  localparam int DEF_V_ACTIVE      = 288;

  typedef enum logic [1:0] {IDLE, ACC, DONE} avg_state_e;
endpackage

// File: rtl/porch_averager.sv
// Accumulates PORCH_SAMPLES cvbs samples per back porch; strobes done with the
// average when the porch closes, or flags a miss if it closed too early.
module porch_averager
  import video_pkg::*;
#(
  parameter int PORCH_SAMPLES = DEF_PORCH_SAMPLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              porch,
  input  logic              porch_rise,
  input  logic              porch_fall,
  input  logic [CVBS_W-1:0] cvbs,
  output logic [CVBS_W-1:0] avg,
  output logic              done,
  output logic              clamp_miss
);
  localparam int SHIFT = $clog2(PORCH_SAMPLES);

  avg_state_e       state_q;
  logic [SUM_W-1:0] sum_q;
  logic [6:0]       cnt_q;
  logic             miss_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
    end else if (ce) begin
      miss_q <= 1'b0;
      case (state_q)
        IDLE: if (porch_rise) begin
          state_q <= ACC;
          sum_q   <= '0;
          cnt_q   <= '0;
        end
        ACC: if (porch_fall) begin
          state_q <= IDLE;
          miss_q  <= 1'b1;
        end else begin
          sum_q <= sum_q + {{(SUM_W-CVBS_W){1'b0}}, cvbs};
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q + 7'd1 == 7'(PORCH_SAMPLES)) state_q <= DONE;
        end
        DONE: if (!porch) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // done is combinational so the clamp loads on the same ce that leaves DONE
  assign done       = ce && (state_q == DONE) && !porch;
  assign avg        = CVBS_W'(sum_q >> SHIFT);
  assign clamp_miss = miss_q;
endmodule

// File: rtl/cvbs_restore.sv
// Black-level restore, gain/saturate, blanking and raster counters.
// CVBS_CLAMP_IIR_EN: low-pass the clamp per line instead of replacing it.
module cvbs_restore
  import video_pkg::*;
#(
  parameter int PORCH_SAMPLES = DEF_PORCH_SAMPLES,
  parameter int GAIN_SHIFT    = DEF_GAIN_SHIFT,
  parameter int H_START       = DEF_H_START,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_START       = DEF_V_START,
  parameter int V_ACTIVE      = DEF_V_ACTIVE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [CVBS_W-1:0]   cvbs,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                porch,
  input  logic [CVBS_W-1:0]   blacklevel,
  output logic [CVBS_W-1:0]   luma,
  output logic                active,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                clamp_valid,
  output logic                clamp_miss
);
  logic                hs_q, hs_d, vs_q, vs_d, porch_q, porch_d;
  logic                hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic [7:0]          clamp_q, clamp_d, clamp_upd;
  logic                clamp_valid_q, clamp_valid_d;
  logic signed [CVBS_W:0] diff, d_q, d_d;
  logic                win_q, win_d, active_q, active_d;
  logic [CVBS_W-1:0]   luma_q, luma_d, clamp6, avg;
  logic [8:0]          scaled;
  logic                hs_fall, vs_fall, porch_rise, porch_fall, avg_done, h_in, v_in;

  assign hs_fall    = hs_q & ~hsync;
  assign vs_fall    = vs_q & ~vsync;
  assign porch_rise = ~porch_q & porch;
  assign porch_fall = porch_q & ~porch;

  porch_averager #(.PORCH_SAMPLES(PORCH_SAMPLES)) u_avg (
    .clk(clk), .reset_n(reset_n), .ce(ce), .porch(porch),
    .porch_rise(porch_rise), .porch_fall(porch_fall), .cvbs(cvbs),
    .avg(avg), .done(avg_done), .clamp_miss(clamp_miss)
  );

`ifdef CVBS_CLAMP_IIR_EN
  logic signed [8:0] clamp_err;
  assign clamp_err = $signed({1'b0, avg, 2'b00}) - $signed({1'b0, clamp_q});
  assign clamp_upd = 8'($signed({1'b0, clamp_q}) + (clamp_err >>> 2));
`else
  assign clamp_upd = {avg, 2'b00};
`endif

  // Until a porch has been measured, trust the detector's coarse estimate
  assign clamp6 = clamp_valid_q ? CVBS_W'(clamp_q >> 2) : blacklevel;
  assign diff   = $signed({1'b0, cvbs}) - $signed({1'b0, clamp6});
  assign h_in   = (int'(hcount_q) >= H_START) && (int'(hcount_q) < H_START + H_ACTIVE);
  assign v_in   = (int'(vcount_q) >= V_START) && (int'(vcount_q) < V_START + V_ACTIVE);
  assign scaled = {3'b000, d_q[CVBS_W-1:0]} << GAIN_SHIFT;

  always_comb begin
    hs_d = hs_q;  vs_d = vs_q;  porch_d = porch_q;
    hs_out_d = hs_out_q;  vs_out_d = vs_out_q;
    hcount_d = hcount_q;  vcount_d = vcount_q;
    clamp_d = clamp_q;  clamp_valid_d = clamp_valid_q;
    d_d = d_q;  win_d = win_q;  luma_d = luma_q;  active_d = active_q;
    if (ce) begin
      hs_d     = hsync;
      vs_d     = vsync;
      porch_d  = porch;
      hs_out_d = hs_q;
      vs_out_d = vs_q;
      hcount_d = hs_fall ? '0 : (&hcount_q) ? hcount_q : hcount_q + 1'b1;
      if (vs_fall)                   vcount_d = '0;
      else if (hs_fall && !(&vcount_q)) vcount_d = vcount_q + 1'b1;
      if (avg_done) begin
        clamp_d       = clamp_valid_q ? clamp_upd : {avg, 2'b00};
        clamp_valid_d = 1'b1;
      end
      d_d      = diff;
      win_d    = h_in && v_in;
      active_d = win_q;
      if (!win_q || d_q[CVBS_W]) luma_d = '0;
      else                       luma_d = (scaled > 9'd63) ? 6'd63 : scaled[CVBS_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_q <= 1'b1;  vs_q <= 1'b1;  porch_q <= 1'b0;
      hs_out_q <= 1'b1;  vs_out_q <= 1'b1;
      hcount_q <= '0;  vcount_q <= '0;
      clamp_q <= '0;  clamp_valid_q <= 1'b0;
      d_q <= '0;  win_q <= 1'b0;  luma_q <= '0;  active_q <= 1'b0;
    end else begin
      hs_q <= hs_d;  vs_q <= vs_d;  porch_q <= porch_d;
      hs_out_q <= hs_out_d;  vs_out_q <= vs_out_d;
      hcount_q <= hcount_d;  vcount_q <= vcount_d;
      clamp_q <= clamp_d;  clamp_valid_q <= clamp_valid_d;
      d_q <= d_d;  win_q <= win_d;  luma_q <= luma_d;  active_q <= active_d;
    end
  end

  assign luma        = luma_q;
  assign active      = active_q;
  assign hsync_out   = hs_out_q;
  assign vsync_out   = vs_out_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign clamp_valid = clamp_valid_q;
endmodule
